// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder path.
//   UART_WORD_W   width of a word accepted from the bus side
//   UART_BYTE_W   width of one byte handed to the transmitter
//   UART_NB_W     width of the "bytes minus one" field
//   UART_ENTRY_W  width of one FIFO entry ({nbytes, data})
//   FEED_*        feeder state encodings, wrapped by feed_state_t
package uart_pkg;

   localparam int UART_WORD_W  = 32;
   localparam int UART_BYTE_W  = 8;
   localparam int UART_NB_W    = 2;
   localparam int UART_ENTRY_W = UART_WORD_W + UART_NB_W;

   localparam logic [1:0] FEED_IDLE = 2'd0;
   localparam logic [1:0] FEED_SEND = 2'd1;
   localparam logic [1:0] FEED_WAIT = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = FEED_IDLE,
      ST_SEND = FEED_SEND,
      ST_WAIT = FEED_WAIT
   } feed_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO for the UART feeder. Head entry is visible on
// rdata whenever the FIFO is not empty (show-ahead).
//   clk, reset_n  clock and async active-low reset (clears pointers/level)
//   push, wdata   write request; ignored while full
//   pop, rdata    read request; ignored while empty; rdata = head entry
//   full, empty   occupancy flags
//   level         entries currently stored, 0..DEPTH
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH  = UART_ENTRY_W,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              pop,
   output logic [WIDTH-1:0]  rdata,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level
);

   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage needs no reset: level gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds 32-bit words to a byte-wide UART transmitter, LSB byte first.
//   clk, reset_n        clock and async active-low reset
//   in_valid/in_ready   word handshake from the bus side (ready = not full)
//   in_data, in_nbytes  word and (byte count - 1)
//   send_pulse          one-cycle start strobe to the transmitter
//   byte_out            byte for the transmitter, held until byte_end
//   byte_end            one-cycle done strobe from the transmitter
//   busy                a word is in progress or words are queued
//   fifo_level          words waiting in the FIFO
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing in flight; pops the FIFO head when one is available
// SEND  | send_pulse high for this single cycle, byte_out valid
// WAIT  | transmitter busy with byte_out; waits for byte_end
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [UART_WORD_W-1:0] in_data,
   input  logic [UART_NB_W-1:0]   in_nbytes,
   output logic                   send_pulse,
   output logic [UART_BYTE_W-1:0] byte_out,
   input  logic                   byte_end,
   output logic                   busy,
   output logic [ADDR_W:0]        fifo_level
);

   feed_state_t              state;
   logic [UART_WORD_W-1:0]   word_r;
   logic [UART_NB_W-1:0]     cnt_r;

   logic [UART_ENTRY_W-1:0]  fifo_rdata;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     fifo_pop;

   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

   uart_tx_fifo #(
      .WIDTH  (UART_ENTRY_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (in_valid),
      .wdata   ({in_nbytes, in_data}),
      .pop     (fifo_pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign in_ready = !fifo_full;
   assign busy     = (state != ST_IDLE) || !fifo_empty;

   // The low byte of the shift register is the transmitter's byte, so it only
   // moves on a pop or on the WAIT->SEND step, never mid-byte.
   assign byte_out = word_r[UART_BYTE_W-1:0];

   // cnt_r counts down the bytes still to go after the current one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         word_r     <= '0;
         cnt_r      <= '0;
         send_pulse <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  word_r     <= fifo_rdata[UART_WORD_W-1:0];
                  cnt_r      <= fifo_rdata[UART_ENTRY_W-1:UART_WORD_W];
                  send_pulse <= 1'b1;
                  state      <= ST_SEND;
               end
            end
            ST_SEND: begin
               send_pulse <= 1'b0;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (byte_end) begin
                  if (cnt_r == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     word_r     <= {{UART_BYTE_W{1'b0}}, word_r[UART_WORD_W-1:UART_BYTE_W]};
                     cnt_r      <= cnt_r - 1'b1;
                     send_pulse <= 1'b1;
                     state      <= ST_SEND;
                  end
               end
            end
            default: begin
               send_pulse <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder. The stimulus side turns every accepted
// word into its expected byte sequence; a negedge monitor (which also plays
// the transmitter) checks each send_pulse against that sequence and checks
// level/busy/ready against word counts.
module tb_uart_tx_feeder;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int QN     = 4096;

   logic              clk       = 1'b0;
   logic              reset_n   = 1'b0;
   logic              in_valid  = 1'b0;
   logic              in_ready;
   logic [31:0]       in_data   = '0;
   logic [1:0]        in_nbytes = '0;
   logic              send_pulse;
   logic [7:0]        byte_out;
   logic              byte_end  = 1'b0;
   logic              busy;
   logic [ADDR_W:0]   fifo_level;

   uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_nbytes  (in_nbytes),
      .send_pulse (send_pulse),
      .byte_out   (byte_out),
      .byte_end   (byte_end),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // expected byte stream, written by the stimulus side only
   logic [7:0] exp_byte  [QN];
   bit         exp_first [QN];
   bit         exp_last  [QN];
   int         wr_idx   = 0;
   int         accepted = 0;

   // monitor-owned state
   int         rd_idx   = 0;
   int         started  = 0;
   int         done     = 0;
   bit         inflight = 1'b0;
   bit         armed    = 1'b0;
   bit         cur_last = 1'b0;
   logic [7:0] held     = '0;
   int         tx_cnt   = 0;
   int         spur_done      = 0;
   int         spur_send_done = 0;
   int         rel_done       = 0;

   // transmitter behaviour, set by the stimulus side
   bit         tx_hold     = 1'b0;
   bit         tx_rand     = 1'b0;
   int         tx_delay    = 3;
   int         tx_rand_max = 0;
   int         spur_req      = 0;
   int         spur_send_req = 0;
   int         rel_req       = 0;

   int         checks = 0;
   int         passed = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                    nm, act, act, exp, exp, $time);
   endtask

   task automatic model_push(input logic [31:0] d, input logic [1:0] nb);
      for (int b = 0; b <= int'(nb); b++) begin
         exp_byte [wr_idx % QN] = d[8*b +: 8];
         exp_first[wr_idx % QN] = (b == 0);
         exp_last [wr_idx % QN] = (b == int'(nb));
         wr_idx++;
      end
      accepted++;
   endtask

   // Call between a negedge and the following posedge.
   task automatic push_word(input logic [31:0] d, input logic [1:0] nb);
      bit ok_now;
      ok_now    = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      in_nbytes = nb;
      for (int w = 0; w < 400; w++) begin
         ok_now = in_ready;
         @(posedge clk);
         if (ok_now) break;
         @(negedge clk); #1;
      end
      if (ok_now) model_push(d, nb);
      chk("push_accepted", ok_now, 1);
      @(negedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (n < budget && !(done == accepted && !busy)) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain_words", done, accepted);
      chk("drain_busy", busy, 0);
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic reset_checks();
      chk("rst_send_pulse", send_pulse, 0);
      chk("rst_byte_out", byte_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_in_ready", in_ready, 1);
   endtask

   // Monitor + transmitter model. byte_end driven here is seen by the DUT at
   // the next posedge and by this block at the next negedge. A strobe only
   // completes a byte if it was driven after the pulse cycle (armed).
   always @(negedge clk) begin
      bit be_prev;
      int idx;
      if (!reset_n) begin
         rd_idx         = wr_idx;
         started        = accepted;
         done           = accepted;
         inflight       = 1'b0;
         armed          = 1'b0;
         byte_end       = 1'b0;
         spur_done      = spur_req;
         spur_send_done = spur_send_req;
         rel_done       = rel_req;
      end else begin
         be_prev  = byte_end;
         byte_end = 1'b0;
         if (be_prev && inflight && armed) begin
            if (cur_last) done++;
            else chk("next_byte_latency", send_pulse, 1);
            inflight = 1'b0;
            armed    = 1'b0;
         end
         if (send_pulse) begin
            chk("pulse_width", inflight, 0);
            if (rd_idx == wr_idx) begin
               chk("spurious_pulse", send_pulse, 0);
            end else begin
               idx = rd_idx % QN;
               chk("byte_out", byte_out, exp_byte[idx]);
               if (exp_first[idx]) started++;
               cur_last = exp_last[idx];
               rd_idx++;
            end
            held     = byte_out;
            inflight = 1'b1;
            armed    = 1'b0;
            tx_cnt   = tx_rand ? int'($urandom_range(tx_rand_max, 0)) : tx_delay;
            if (spur_send_req != spur_send_done) begin
               byte_end = 1'b1;
               spur_send_done++;
            end
         end else if (inflight) begin
            chk("byte_out_stable", byte_out, held);
            armed = 1'b1;
         end
         chk("fifo_level", fifo_level, accepted - started);
         chk("in_ready", in_ready, (accepted - started) != DEPTH);
         chk("busy", busy, accepted != done);
         if (inflight && armed) begin
            if (tx_hold) begin
               if (rel_req != rel_done) begin
                  byte_end = 1'b1;
                  rel_done++;
               end
            end else if (tx_cnt == 0) begin
               byte_end = 1'b1;
            end else begin
               tx_cnt--;
            end
         end else if (!inflight && spur_req != spur_done) begin
            byte_end = 1'b1;
            spur_done++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      repeat (3) @(negedge clk);
      #1;
      reset_checks();
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // single byte, first-word latency
      tx_delay = 5;
      push_word(32'h0000_00A5, 2'd0);
      chk("first_latency_pre", send_pulse, 0);
      @(negedge clk); #1;
      chk("first_latency", send_pulse, 1);
      chk("first_byte", byte_out, 8'hA5);
      drain(200);

      // full word, slow transmitter
      tx_delay = 350;
      push_word(32'h4433_2211, 2'd3);
      drain(2000);

      // spurious strobes while idle and during SEND
      spur_req++;
      repeat (5) @(negedge clk);
      #1;
      chk("spur_idle_busy", busy, 0);
      spur_send_req++;
      tx_delay = 4;
      push_word(32'h0000_BEEF, 2'd1);
      drain(200);
      chk("spur_send_used", spur_send_done, spur_send_req);

      // fill the FIFO with the transmitter stalled
      tx_hold = 1'b1;
      for (int i = 0; i < 9; i++) push_word($urandom, 2'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("full_level", fifo_level, DEPTH);
      chk("full_in_ready", in_ready, 0);
      d = $urandom;
      in_valid  = 1'b1;
      in_data   = d;
      in_nbytes = 2'd0;
      repeat (10) @(negedge clk);
      #1;
      chk("full_hold_level", fifo_level, DEPTH);
      rel_req++;
      push_word(d, 2'd0);
      chk("full_refill_level", fifo_level, DEPTH);

      // drain down to 3 queued, one byte at a time
      for (int i = 0; i < 5; i++) begin
         rel_req++;
         repeat (4) @(negedge clk);
         #1;
      end
      chk("pre_sim_level", fifo_level, 3);

      // push lands on the same edge as the IDLE pop
      rel_req++;
      @(negedge clk);
      @(negedge clk);
      #1;
      push_word(32'hC0DE_0042, 2'd0);
      chk("sim_level", fifo_level, 3);
      chk("sim_pulse", send_pulse, 1);
      tx_hold  = 1'b0;
      tx_delay = 2;
      drain(500);

      // randomized traffic
      tx_rand     = 1'b1;
      tx_rand_max = 6;
      for (int i = 0; i < 60; i++) begin
         push_word($urandom, 2'($urandom_range(3, 0)));
         repeat ($urandom_range(3, 0)) @(negedge clk);
         #1;
      end
      drain(5000);

      // reset in the middle of a word with two more queued
      tx_rand  = 1'b0;
      tx_delay = 20;
      push_word(32'h0D0C_0B0A, 2'd3);
      push_word($urandom, 2'd1);
      push_word($urandom, 2'd2);
      repeat (30) @(negedge clk);
      #1;
      chk("pre_reset_busy", busy, 1);
      chk("pre_reset_level", fifo_level, 2);
      #2;
      reset_n = 1'b0;
      #1;
      reset_checks();
      repeat (3) @(negedge clk);
      #1;
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      chk("post_reset_level", fifo_level, 0);
      chk("post_reset_pulse", send_pulse, 0);
      tx_delay = 2;
      push_word(32'h0000_005A, 2'd0);
      drain(200);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmit state machine. Accepts 32-bit words from the core/bus side over a valid/ready handshake and buffers them in a small FIFO.
- Splits each word into 1–4 bytes, LSB first. For each byte it drives the transmitter's byte input and start pulse, then waits for the transmitter's byte-done strobe.
- Lets software queue several words without polling the transmitter per byte.

Parameters:
- DEPTH, 8, FIFO depth in words; power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  FIFO can accept a word (= not full).
- in_data  in  32  word to send; byte 0 = in_data[7:0], sent first.
- in_nbytes  in  2  bytes to send minus one (0 → 1 byte … 3 → 4 bytes).
- send_pulse  out  1  one-cycle start strobe to the transmitter.
- byte_out  out  8  byte to the transmitter; stable from send_pulse until byte_end.
- byte_end  in  1  one-cycle done strobe from the transmitter.
- busy  out  1  high while a word is being serialised or the FIFO is non-empty.
- fifo_level  out  ADDR_W+1  words currently stored (0..DEPTH).

Behaviour:
- Reset (reset_n low, async): FIFO empty, pointers 0, state IDLE, send_pulse 0, byte_out 0x00, busy 0, fifo_level 0, in_ready 1 (valid immediately after reset).
- Push: a word is written on the rising edge where in_valid && in_ready. in_ready depends only on full; there is no same-cycle pop bypass.
- FIFO storage: 34 bits per entry ({in_nbytes, in_data}). Wrap-around uses ADDR_W-bit pointers plus level counter; full when level == DEPTH.
- in_valid while full: not accepted, no state change; upstream must hold.
- FSM states (Moore, registered):
  - IDLE: if level != 0, pop head into shift reg word_r and cnt_r = nbytes; go to SEND. Otherwise stay.
  - SEND: send_pulse = 1 for exactly this one cycle; go to WAIT.
  - WAIT: send_pulse = 0. On byte_end, if cnt_r == 0, go to IDLE. Otherwise word_r >>= 8, cnt_r -= 1, go to SEND. Without byte_end, stay.
- byte_out = word_r[7:0] (registered). It changes only on a WAIT→SEND transition or an IDLE pop, never while the transmitter is sending.
- Latency: word pushed at edge E0 → IDLE pops at E1 → send_pulse high in the cycle after E1. Between bytes: byte_end cycle → send_pulse in the next cycle. Between words: one extra IDLE cycle.
- Simultaneous push and pop in the same edge: level unchanged; both pointers advance.
- byte_end in IDLE or SEND: ignored.
- busy = (state != IDLE) || (level != 0).
- Reset mid-word: remaining bytes and all FIFO contents are discarded. The top level drives the transmitter's active-high synchronous reset from the synchronised inverse of reset_n, so both blocks restart idle.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: FEED_IDLE = 0, FEED_SEND = 1, FEED_WAIT = 2;
  - UART_WORD_W = 32;
  - UART_BYTE_W = 8.
- One sub-module, uart_tx_fifo (parameterised width/depth synchronous FIFO: push, pop, full, empty, level). The FSM, shift register and byte counter stay in uart_tx_feeder.

Test Plan:
- Single byte: push 0x000000A5, nbytes = 0 → one send_pulse; byte_out = 0xA5 held until byte_end; busy drops one cycle after byte_end; no second pulse.
- Full word: push 0x44332211, nbytes = 3 (transmitter model answers byte_end 350 cycles after each pulse) → bytes 0x11, 0x22, 0x33, 0x44 in order. Exactly 4 pulses, each 1 cycle after the previous byte_end.
- FIFO full: hold the transmitter (no byte_end), push 9 words → the first is popped, 8 remain, fifo_level = 8, in_ready = 0. The 10th word is not accepted until one byte_end frees a slot. All accepted words are transmitted in order.
- Simultaneous push and pop: push on the same edge IDLE pops with level = 3 → level stays 3, pointers wrap past DEPTH−1 correctly, data order is preserved.
- Spurious strobe: pulse byte_end while IDLE and during SEND → no state change, no extra send_pulse.
- Reset mid-word: assert reset_n low during byte 2 of a 4-byte word with 2 words queued → outputs return to reset values asynchronously. After release, fifo_level = 0, no pulses until a new push.
